// File: rtl/ieee754_mult_seq.sv
// Sequential IEEE-754 single-precision multiplier.
// The mantissa product is built by 24 shift-add steps. Rounding is round to
// nearest, ties to even. Denormal inputs are flushed to zero.
module ieee754_mult_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] dataR,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        unf,
  output logic        nan
);

  localparam int unsigned FP_W      = 32;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned SIG_W     = 24;
  localparam int unsigned PROD_W    = 48;
  localparam int unsigned E_W       = 10;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned LAST_ITER = 23;
  localparam int unsigned BIAS      = 127;
  localparam int unsigned EXP_INF   = 255;
  localparam logic [FP_W-1:0] QNAN  = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MULT   = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [FP_W-1:0]       opa_q, opa_d;
  logic [FP_W-1:0]       opb_q, opb_d;
  logic [SIG_W-1:0]      mcand_q, mcand_d;
  logic [PROD_W-1:0]     prod_q, prod_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic signed [E_W-1:0] exp_q, exp_d;
  logic                  sign_q, sign_d;
  logic                  sticky_q, sticky_d;
  logic [FP_W-1:0]       res_q, res_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  nan_q, nan_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Operand fields and classification
  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              is_special, is_nan_res;
  logic [FP_W-1:0]   spec_res;

  assign sa = opa_q[FP_W-1];
  assign sb = opb_q[FP_W-1];
  assign ea = opa_q[FP_W-2:FRAC_W];
  assign eb = opb_q[FP_W-2:FRAC_W];
  assign fa = opa_q[FRAC_W-1:0];
  assign fb = opb_q[FRAC_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  assign is_nan_res = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
  assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  // Result for the special cases that bypass the datapath
  always_comb begin
    spec_res = {sa ^ sb, {(FP_W-1){1'b0}}};
    if (is_nan_res) begin
      spec_res = QNAN;
    end else if (a_inf | b_inf) begin
      spec_res = {sa ^ sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end
  end

  // One shift-add step: add multiplicand to the upper half, then shift right
  logic [SIG_W:0] mult_sum;
  assign mult_sum = {1'b0, prod_q[PROD_W-1:SIG_W]}
                  + {1'b0, (prod_q[0] ? mcand_q : {SIG_W{1'b0}})};

  // Round to nearest even on the normalised product (hidden bit at 46)
  logic                  rnd_guard, rnd_sticky, rnd_up;
  logic [SIG_W:0]        rnd_sum;
  logic [FRAC_W-1:0]     rnd_frac;
  logic signed [E_W-1:0] rnd_exp;
  logic                  rnd_ovf, rnd_unf;
  logic [FP_W-1:0]       rnd_res;

  assign rnd_guard  = prod_q[FRAC_W-1];
  assign rnd_sticky = sticky_q | (|prod_q[FRAC_W-2:0]);
  assign rnd_up     = rnd_guard & (rnd_sticky | prod_q[FRAC_W]);
  assign rnd_sum    = {1'b0, prod_q[PROD_W-2:FRAC_W]} + (SIG_W+1)'(rnd_up);
  // A carry out leaves bits 23:0 all zero, so the fraction becomes 1.0
  assign rnd_frac   = rnd_sum[SIG_W-1] ? rnd_sum[FRAC_W-1:0] : {FRAC_W{1'b0}};
  assign rnd_exp    = rnd_sum[SIG_W] ? (exp_q + $signed(E_W'(1))) : exp_q;
  assign rnd_ovf    = (rnd_exp >= $signed(E_W'(EXP_INF)));
  assign rnd_unf    = (rnd_exp <= $signed(E_W'(0)));

  // Pack the rounded result, saturating to infinity or flushing to zero
  always_comb begin
    rnd_res = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
    if (rnd_ovf) begin
      rnd_res = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (rnd_unf) begin
      rnd_res = {sign_q, {(FP_W-1){1'b0}}};
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_UNPACK;
      S_UNPACK: state_d = is_special ? S_DONE : S_MULT;
      S_MULT:   if (cnt_q == CNT_W'(LAST_ITER)) state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values, per state
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sticky_d = sticky_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    nan_d    = nan_q;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d = dataA;
          opb_d = dataB;
        end
      end
      S_UNPACK: begin
        sign_d = sa ^ sb;
        if (is_special) begin
          res_d  = spec_res;
          nan_d  = is_nan_res;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          done_d = 1'b1;
        end else begin
          mcand_d  = {1'b1, fa};
          prod_d   = {{SIG_W{1'b0}}, 1'b1, fb};
          cnt_d    = '0;
          sticky_d = 1'b0;
          exp_d    = $signed(E_W'(ea)) + $signed(E_W'(eb)) - $signed(E_W'(BIAS));
        end
      end
      S_MULT: begin
        prod_d = {mult_sum, prod_q[SIG_W-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
      end
      S_NORM: begin
        if (prod_q[PROD_W-1]) begin
          prod_d   = {1'b0, prod_q[PROD_W-1:1]};
          sticky_d = prod_q[0];
          exp_d    = exp_q + $signed(E_W'(1));
        end
      end
      S_ROUND: begin
        res_d  = rnd_res;
        ovf_d  = rnd_ovf;
        unf_d  = ~rnd_ovf & rnd_unf;
        nan_d  = 1'b0;
        done_d = 1'b1;
      end
      S_DONE: begin
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opa_q    <= '0;
      opb_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      nan_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      nan_q    <= nan_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dataR = res_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign nan   = nan_q;

endmodule
